// File: rtl/accum_16bit_if.sv
// Operand stream, run control and result bus of the multi-operand accumulator.
// The master drives control and operands; the slave (accumulator) returns status and the total.
interface accum_16bit_if #(
  parameter int CNT_BITS = 8
);
  logic                start;
  logic [CNT_BITS-1:0] count;
  logic                abort;
  logic                in_valid;
  logic [15:0]         in_data;
  logic                in_ready;
  logic                busy;
  logic                done;
  logic [15:0]         result;
  logic                overflow_flag;

  modport master (
    output start, count, abort, in_valid, in_data,
    input  in_ready, busy, done, result, overflow_flag
  );

  modport slave (
    input  start, count, abort, in_valid, in_data,
    output in_ready, busy, done, result, overflow_flag
  );
endinterface

// File: rtl/accum_16bit.sv
// Sequential accumulator: sums a programmed number of stream operands through one
// adder_16bit, then reports the wrapped total, a sticky carry-out flag and a done pulse.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, carry_in};
endmodule

module accum_16bit_chk (
  input logic        clk,
  input logic        start,
  input logic        abort,
  input logic        in_valid,
  input logic [15:0] in_data
);
  // flag non-0/1 control levels and operand bits at every edge
  always_ff @(posedge clk) begin
    assert (!$isunknown({start, abort, in_valid}))
      else $error("accum_16bit: start/abort/in_valid not 0/1");
    if (in_valid === 1'b1) begin
      assert (!$isunknown(in_data))
        else $error("accum_16bit: in_data has non-0/1 bits while in_valid");
    end
  end
endmodule

module accum_16bit #(
  parameter int CNT_BITS = 8
) (
  input logic          clk,
  input logic          rst,
  accum_16bit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r, state_n;
  logic [15:0]         acc_r, acc_n;
  logic [15:0]         result_r, result_n;
  logic [CNT_BITS-1:0] remaining_r, remaining_n;
  logic                ovf_r, ovf_n;
  logic [15:0]         sum_s;
  logic                carry_s;
  logic                hs_s;

  adder_16bit u_adder (
    .a        (acc_r),
    .b        (bus.in_data),
    .carry_in (1'b0),
    .sum      (sum_s),
    .overflow (carry_s)
  );

  accum_16bit_chk u_chk (
    .clk      (clk),
    .start    (bus.start),
    .abort    (bus.abort),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data)
  );

  assign hs_s = bus.in_valid && (state_r == ACCUM);

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 16'h0000;
      result_r    <= 16'h0000;
      remaining_r <= '0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      acc_r       <= acc_n;
      result_r    <= result_n;
      remaining_r <= remaining_n;
      ovf_r       <= ovf_n;
    end
  end

  // next-state and next-register values; abort outranks the handshake
  always_comb begin
    state_n     = state_r;
    acc_n       = acc_r;
    result_n    = result_r;
    remaining_n = remaining_r;
    ovf_n       = ovf_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          ovf_n = 1'b0;
          if (bus.count != '0) begin
            acc_n       = 16'h0000;
            remaining_n = bus.count;
            state_n     = ACCUM;
          end else begin
            result_n = 16'h0000;
            state_n  = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCUM: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (hs_s) begin
          acc_n       = sum_s;
          ovf_n       = ovf_r | carry_s;
          remaining_n = remaining_r - CNT_BITS'(1);
          if (remaining_r == CNT_BITS'(1)) begin
            result_n = sum_s;
            state_n  = DONE;
          end else begin
            state_n = ACCUM;
          end
        end else begin
          state_n = ACCUM;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.in_ready      = (state_r == ACCUM);
  assign bus.busy          = (state_r == ACCUM);
  assign bus.done          = (state_r == DONE);
  assign bus.result        = result_r;
  assign bus.overflow_flag = ovf_r;
endmodule

// File: tb/tb_accum_16bit.sv
// Directed self-checking bench for accum_16bit: inputs change and outputs are
// checked on the falling edge, so each check sees the state after the last rising edge.
module tb_accum_16bit;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  accum_16bit_if #(.CNT_BITS(8)) bus ();

  accum_16bit #(.CNT_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic busy_e, input logic done_e,
                              input logic [15:0] result_e, input logic ovf_e);
    check1({tag, ".busy"}, bus.busy, busy_e);
    check1({tag, ".in_ready"}, bus.in_ready, busy_e);
    check1({tag, ".done"}, bus.done, done_e);
    check16({tag, ".result"}, bus.result, result_e);
    check1({tag, ".ovf"}, bus.overflow_flag, ovf_e);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.count    = 8'd0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    @(negedge clk);
    tick();
    check_status("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    tick();

    // basic sum 1+2+3
    bus.start = 1'b1; bus.count = 8'd3;
    tick();
    check_status("sum.start", 1'b1, 1'b0, 16'h0000, 1'b0);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0001;
    tick();
    bus.in_data = 16'h0002;
    tick();
    check_status("sum.mid", 1'b1, 1'b0, 16'h0000, 1'b0);
    bus.in_data = 16'h0003;
    tick();
    check_status("sum.done", 1'b0, 1'b1, 16'h0006, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check_status("sum.hold", 1'b0, 1'b0, 16'h0006, 1'b0);

    // wrap with carry out, then a clean run clears the flag
    bus.start = 1'b1; bus.count = 8'd2;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'hFFFF;
    tick();
    bus.in_data = 16'h0002;
    tick();
    check_status("wrap.done", 1'b0, 1'b1, 16'h0001, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check_status("wrap.hold", 1'b0, 1'b0, 16'h0001, 1'b1);
    bus.start = 1'b1; bus.count = 8'd1;
    tick();
    check_status("clean.start", 1'b1, 1'b0, 16'h0001, 1'b0);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0005;
    tick();
    check_status("clean.done", 1'b0, 1'b1, 16'h0005, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // stalls: in_valid 1,0,0,1; stalled data must not be summed
    bus.start = 1'b1; bus.count = 8'd2;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0010;
    tick();
    bus.in_valid = 1'b0; bus.in_data = 16'h0100;
    tick();
    check_status("stall.1", 1'b1, 1'b0, 16'h0005, 1'b0);
    tick();
    check_status("stall.2", 1'b1, 1'b0, 16'h0005, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 16'h0020;
    tick();
    check_status("stall.done", 1'b0, 1'b1, 16'h0030, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check_status("stall.once", 1'b0, 1'b0, 16'h0030, 1'b0);

    // abort together with the 2nd operand
    bus.start = 1'b1; bus.count = 8'd3;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0007;
    tick();
    bus.in_data = 16'h0009; bus.abort = 1'b1;
    tick();
    check_status("abort.idle", 1'b0, 1'b0, 16'h0030, 1'b0);
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    tick();
    check_status("abort.nodone", 1'b0, 1'b0, 16'h0030, 1'b0);

    // abort beats the final handshake
    bus.start = 1'b1; bus.count = 8'd1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0004; bus.abort = 1'b1;
    tick();
    check_status("abortfin", 1'b0, 1'b0, 16'h0030, 1'b0);
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    tick();
    check1("abortfin.after.done", bus.done, 1'b0);

    // zero count: done next cycle, result cleared; abort in IDLE ignored
    bus.start = 1'b1; bus.count = 8'd0; bus.abort = 1'b1;
    tick();
    check_status("zero.done", 1'b0, 1'b1, 16'h0000, 1'b0);
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
    check_status("zero.idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // start during ACCUM and during DONE is ignored
    bus.start = 1'b1; bus.count = 8'd2;
    tick();
    bus.count = 8'd5; bus.in_valid = 1'b1; bus.in_data = 16'h0001;
    tick();
    check_status("ign.mid", 1'b1, 1'b0, 16'h0000, 1'b0);
    bus.in_data = 16'h0002;
    tick();
    check_status("ign.done", 1'b0, 1'b1, 16'h0003, 1'b0);
    bus.count = 8'd1; bus.in_valid = 1'b0;
    tick();
    check_status("ign.idle", 1'b0, 1'b0, 16'h0003, 1'b0);
    bus.start = 1'b0;
    tick();
    check_status("ign.norun", 1'b0, 1'b0, 16'h0003, 1'b0);

    // reset mid-run after 2 operands with carry out pending
    bus.start = 1'b1; bus.count = 8'd4;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h8000;
    tick();
    tick();
    check_status("midrun.ovf", 1'b1, 1'b0, 16'h0003, 1'b1);
    rst = 1'b1; bus.in_valid = 1'b0;
    tick();
    check_status("midrun.rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    bus.start = 1'b1; bus.count = 8'd1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'hABCD;
    tick();
    check_status("postrst.done", 1'b0, 1'b1, 16'hABCD, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
